// File: rtl/seg7_bcd_reader.sv
// -----------------------------------------------------------------------------
// seg7_bcd_reader
//
// Reads a two-digit seven-segment display (plus a hundreds/overflow flag) and
// turns a stable, decodable pattern into BCD digits and an 8-bit binary value.
// The result is offered on a valid/ready handshake. A stable pattern that is
// not decodable produces a one-cycle err pulse.
//
// Every edge samples {ov_in, Seg_1, Seg_0}. A pattern is acted on only after
// STABLE_CYC consecutive edges have seen the same value. A pattern that has
// been handled once is not handled again until the input moves away from it.
//
// Optional feature macro: SEG7_BCD_READER_ERRCNT_EN
//   defined   : err_cnt counts err pulses, saturating at 255, cleared by rst
//   undefined : err_cnt is tied to 0
//
// Ports
//   clk      in   1  clock, all state changes on the rising edge
//   rst      in   1  synchronous active-high reset
//   Seg_0    in   7  ones digit segments, [6]=a .. [0]=g, active-high
//   Seg_1    in   7  tens digit segments, same bit order
//   ov_in    in   1  hundreds/overflow flag travelling with the digit pair
//   ready    in   1  downstream accepts the presented result
//   D0       out  4  ones BCD digit
//   D1       out  4  tens BCD digit
//   ov_out   out  1  overflow flag of the decoded pair
//   bin      out  8  100*ov_out + 10*D1 + D0
//   valid    out  1  result presented
//   err      out  1  one-cycle pulse for a stable, undecodable pattern
//   err_cnt  out  8  error count (see macro above)
// -----------------------------------------------------------------------------
module seg7_bcd_reader #(
    parameter int STABLE_CYC = 4      // legal range 2..255
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [6:0] Seg_0,
    input  logic [6:0] Seg_1,
    input  logic       ov_in,
    input  logic       ready,
    output logic [3:0] D0,
    output logic [3:0] D1,
    output logic       ov_out,
    output logic [7:0] bin,
    output logic       valid,
    output logic       err,
    output logic [7:0] err_cnt
);

    localparam logic [7:0] CNT_MAX = 8'(STABLE_CYC - 1);

    typedef enum logic [1:0] {
        SETTLE   = 2'd0,
        PRESENT  = 2'd1,
        WAIT_CHG = 2'd2
    } state_t;

    state_t      r_state;
    state_t      w_state_next;
    logic [14:0] r_smp;
    logic [14:0] r_lastpat;
    logic [7:0]  r_cnt;
    logic [3:0]  r_d0;
    logic [3:0]  r_d1;
    logic        r_ov;
    logic [7:0]  r_bin;
    logic        r_valid;
    logic        r_err;

    logic [14:0] w_in;
    logic        w_same;
    logic        w_stable;
    logic        w_blank;
    logic        w_legal;
    logic [7:0]  w_bin;
    logic        w_take;
    logic        w_load;
    logic        w_err_set;
    logic        w_valid_clr;

    // Decoded digits: [4] = pattern is a legal digit, [3:0] = digit value.
    logic [6:0]  w_seg [2];
    logic [4:0]  w_dec [2];

    assign w_in     = {ov_in, Seg_1, Seg_0};
    assign w_same   = (w_in == r_smp);
    // r_cnt saturated means the previous STABLE_CYC samples matched; the
    // current input must match as well for the pattern to count as stable.
    assign w_stable = w_same && (r_cnt == CNT_MAX);
    assign w_seg[0] = Seg_0;
    assign w_seg[1] = Seg_1;

    function automatic logic [4:0] seg_decode(input logic [6:0] p);
        case (p)
            7'h7E:   return {1'b1, 4'd0};
            7'h30:   return {1'b1, 4'd1};
            7'h6D:   return {1'b1, 4'd2};
            7'h79:   return {1'b1, 4'd3};
            7'h33:   return {1'b1, 4'd4};
            7'h5B:   return {1'b1, 4'd5};
            7'h5F:   return {1'b1, 4'd6};
            7'h70:   return {1'b1, 4'd7};
            7'h7F:   return {1'b1, 4'd8};
            7'h7B:   return {1'b1, 4'd9};
            // A single blank digit next to a lit one is not decodable either.
            default: return 5'd0;
        endcase
    endfunction

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_dec
            assign w_dec[gi] = seg_decode(w_seg[gi]);
        end
    endgenerate

    assign w_blank = (Seg_0 == 7'h00) && (Seg_1 == 7'h00);
    assign w_legal = w_dec[0][4] && w_dec[1][4];
    assign w_bin   = (ov_in ? 8'd100 : 8'd0)
                   + ({4'd0, w_dec[1][3:0]} * 8'd10)
                   + {4'd0, w_dec[0][3:0]};

    always_comb begin
        w_state_next = r_state;
        w_take       = 1'b0;
        w_load       = 1'b0;
        w_err_set    = 1'b0;
        w_valid_clr  = 1'b0;
        case (r_state)
            SETTLE: begin
                if (w_stable) begin
                    w_take = 1'b1;
                    if (w_blank) begin
                        w_state_next = WAIT_CHG;
                    end else if (w_legal) begin
                        w_load       = 1'b1;
                        w_state_next = PRESENT;
                    end else begin
                        w_err_set    = 1'b1;
                        w_state_next = WAIT_CHG;
                    end
                end
            end
            PRESENT: begin
                if (ready) begin
                    w_valid_clr  = 1'b1;
                    w_state_next = WAIT_CHG;
                end
            end
            WAIT_CHG: begin
                // Re-arm only once the display shows something new.
                if (w_in != r_lastpat) begin
                    w_state_next = SETTLE;
                end
            end
            default: w_state_next = SETTLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= SETTLE;
            r_smp     <= '0;
            r_cnt     <= '0;
            r_lastpat <= '0;
            r_d0      <= '0;
            r_d1      <= '0;
            r_ov      <= 1'b0;
            r_bin     <= '0;
            r_valid   <= 1'b0;
            r_err     <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_smp   <= w_in;
            if (!w_same) begin
                r_cnt <= '0;
            end else if (r_cnt != CNT_MAX) begin
                r_cnt <= r_cnt + 8'd1;
            end
            if (w_take) begin
                r_lastpat <= w_in;
            end
            if (w_load) begin
                r_d0    <= w_dec[0][3:0];
                r_d1    <= w_dec[1][3:0];
                r_ov    <= ov_in;
                r_bin   <= w_bin;
                r_valid <= 1'b1;
            end else if (w_valid_clr) begin
                r_valid <= 1'b0;
            end
            r_err <= w_err_set;
        end
    end

`ifdef SEG7_BCD_READER_ERRCNT_EN
    logic [7:0] r_err_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_err_cnt <= '0;
        end else if (w_err_set && (r_err_cnt != 8'hFF)) begin
            r_err_cnt <= r_err_cnt + 8'd1;
        end
    end

    assign err_cnt = r_err_cnt;
`else
    assign err_cnt = 8'd0;
`endif

    assign D0     = r_d0;
    assign D1     = r_d1;
    assign ov_out = r_ov;
    assign bin    = r_bin;
    assign valid  = r_valid;
    assign err    = r_err;

endmodule

// File: tb/tb_seg7_bcd_reader.sv
// -----------------------------------------------------------------------------
// tb_seg7_bcd_reader
//
// Drives directed and random display patterns into seg7_bcd_reader. A
// reference model fed with the same stimulus keeps a short history of samples
// to judge stability, pushes every expected result/err event into a queue and
// tracks the expected output levels. A separate monitor pops the queue when
// the DUT raises valid or err and compares the outputs every cycle.
// -----------------------------------------------------------------------------
module tb_seg7_bcd_reader;

    localparam int STABLE_CYC = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [6:0] Seg_0 = '0;
    logic [6:0] Seg_1 = '0;
    logic       ov_in = 1'b0;
    logic       ready = 1'b0;
    logic [3:0] D0;
    logic [3:0] D1;
    logic       ov_out;
    logic [7:0] bin;
    logic       valid;
    logic       err;
    logic [7:0] err_cnt;

    seg7_bcd_reader #(.STABLE_CYC(STABLE_CYC)) dut (
        .clk     (clk),
        .rst     (rst),
        .Seg_0   (Seg_0),
        .Seg_1   (Seg_1),
        .ov_in   (ov_in),
        .ready   (ready),
        .D0      (D0),
        .D1      (D1),
        .ov_out  (ov_out),
        .bin     (bin),
        .valid   (valid),
        .err     (err),
        .err_cnt (err_cnt)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Event: kind 0 = result {ov, d1, d0, bin}, kind 1 = err pulse.
    typedef struct packed {
        logic        kind;
        logic [16:0] data;
    } ev_t;
    ev_t exp_q[$];

    logic [6:0] digit_pat [10] = '{7'h7E, 7'h30, 7'h6D, 7'h79, 7'h33,
                                   7'h5B, 7'h5F, 7'h70, 7'h7F, 7'h7B};

    // ---------------- reference model ----------------
    localparam int M_SETTLE = 0, M_SHOW = 1, M_WAIT = 2;
    logic [14:0] hist[$];
    int          m_mode;
    logic [14:0] m_last;
    int          m_d0, m_d1, m_bin;
    logic        m_ov, m_valid, m_err;
    int          m_errcnt;

    function automatic int digit_of(input logic [6:0] p);
        for (int i = 0; i < 10; i++)
            if (digit_pat[i] == p) return i;
        return -1;
    endfunction

    task automatic model_step();
        logic [14:0] x;
        logic        stable;
        int          d0, d1;
        x = {ov_in, Seg_1, Seg_0};
        if (rst) begin
            hist.delete();
            hist.push_back(15'h0);   // reset behaves like a sample of zeros
            m_mode = M_SETTLE; m_last = '0;
            m_d0 = 0; m_d1 = 0; m_bin = 0; m_ov = 0;
            m_valid = 0; m_err = 0; m_errcnt = 0;
            return;
        end
        m_err = 0;
        hist.push_back(x);
        if (hist.size() > STABLE_CYC + 1) void'(hist.pop_front());
        stable = (hist.size() == STABLE_CYC + 1);
        foreach (hist[i]) if (hist[i] != x) stable = 0;
        case (m_mode)
            M_SETTLE: if (stable) begin
                m_last = x;
                d0 = digit_of(x[6:0]);
                d1 = digit_of(x[13:7]);
                if (x[13:0] == 14'h0) begin
                    m_mode = M_WAIT;
                end else if (d0 >= 0 && d1 >= 0) begin
                    m_d0 = d0; m_d1 = d1; m_ov = x[14];
                    m_bin = (x[14] ? 100 : 0) + 10 * d1 + d0;
                    m_valid = 1;
                    exp_q.push_back({1'b0, m_ov, 4'(m_d1), 4'(m_d0), 8'(m_bin)});
                    m_mode = M_SHOW;
                end else begin
                    m_err = 1;
`ifdef SEG7_BCD_READER_ERRCNT_EN
                    if (m_errcnt < 255) m_errcnt++;
`endif
                    exp_q.push_back({1'b1, 17'h0});
                    m_mode = M_WAIT;
                end
            end
            M_SHOW: if (ready) begin
                m_valid = 0;
                m_mode = M_WAIT;
            end
            default: if (x != m_last) m_mode = M_SETTLE;
        endcase
    endtask

    // ---------------- stimulus helpers ----------------
    task automatic cyc(input logic [14:0] x, input logic r, input logic rs);
        @(negedge clk);
        {ov_in, Seg_1, Seg_0} = x;
        ready = r;
        rst   = rs;
        @(posedge clk);
        model_step();
    endtask

    task automatic hold(input logic [14:0] x, input int n, input logic r);
        for (int i = 0; i < n; i++) cyc(x, r, 1'b0);
    endtask

    function automatic logic [14:0] pat(input logic ov, input logic [6:0] s1,
                                        input logic [6:0] s0);
        return {ov, s1, s0};
    endfunction

    // ---------------- monitor ----------------
    initial begin
        logic        prev_valid;
        ev_t         e;
        logic [26:0] got, exp;
        prev_valid = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            got = {valid, err, D1, D0, ov_out, bin, err_cnt};
            exp = {m_valid, m_err, 4'(m_d1), 4'(m_d0), m_ov, 8'(m_bin), 8'(m_errcnt)};
            n_tests++;
            if (got !== exp) begin
                n_fail++;
                $display("FAIL levels t=%0t got v=%b e=%b D1=%0d D0=%0d ov=%b bin=%0d cnt=%0d want v=%b e=%b D1=%0d D0=%0d ov=%b bin=%0d cnt=%0d",
                         $time, got[26], got[25], got[24:21], got[20:17], got[16], got[15:8], got[7:0],
                         exp[26], exp[25], exp[24:21], exp[20:17], exp[16], exp[15:8], exp[7:0]);
            end
            if ((valid && !prev_valid) || err) begin
                n_tests++;
                if (exp_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL event t=%0t unexpected valid=%b err=%b bin=%0d", $time, valid, err, bin);
                end else begin
                    e = exp_q.pop_front();
                    if (err) begin
                        if (e.kind !== 1'b1) begin
                            n_fail++;
                            $display("FAIL err_event t=%0t got err pulse want result bin=%0d", $time, e.data[7:0]);
                        end else
                            $display("[TB] t=%0t err pulse err_cnt=%0d", $time, err_cnt);
                    end else if (e.kind !== 1'b0 || e.data !== {ov_out, D1, D0, bin}) begin
                        n_fail++;
                        $display("FAIL result t=%0t got ov=%b D1=%0d D0=%0d bin=%0d want kind=%b ov=%b D1=%0d D0=%0d bin=%0d",
                                 $time, ov_out, D1, D0, bin, e.kind, e.data[16], e.data[15:12], e.data[11:8], e.data[7:0]);
                    end else
                        $display("[TB] t=%0t result D1=%0d D0=%0d ov=%b bin=%0d", $time, D1, D0, ov_out, bin);
                end
            end
            prev_valid = valid;
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog time limit reached");
        $fatal(1);
    end

    // ---------------- stimulus ----------------
    initial begin
        logic [14:0] x;
        int          r, len;

        cyc(15'h0, 1'b0, 1'b1);
        cyc(15'h0, 1'b0, 1'b1);

        // 125 presented after STABLE_CYC edges, held while ready=0
        hold(pat(1'b1, 7'h6D, 7'h5B), 12, 1'b0);
        cyc(pat(1'b1, 7'h6D, 7'h5B), 1'b1, 1'b0);
        hold(pat(1'b1, 7'h6D, 7'h5B), 20, 1'b1);   // no re-emission

        // undecodable ones digit
        hold(pat(1'b0, 7'h30, 7'h7C), 10, 1'b0);

        // chatter between 1 and 3, then settle on 3
        for (int i = 0; i < 10; i++)
            hold(pat(1'b0, 7'h30, (i % 2) ? 7'h79 : 7'h30), 2, 1'b0);
        hold(pat(1'b0, 7'h30, 7'h79), 8, 1'b0);
        cyc(pat(1'b0, 7'h30, 7'h79), 1'b1, 1'b0);

        // reset during a presentation, then blank display
        hold(pat(1'b0, 7'h33, 7'h70), 8, 1'b0);
        cyc(pat(1'b0, 7'h33, 7'h70), 1'b1, 1'b1);
        hold(15'h0, 12, 1'b0);

        // extremes: 199 then 0
        hold(pat(1'b1, 7'h7B, 7'h7B), 8, 1'b0);
        cyc(pat(1'b1, 7'h7B, 7'h7B), 1'b1, 1'b0);
        hold(pat(1'b0, 7'h7E, 7'h7E), 8, 1'b0);
        cyc(pat(1'b0, 7'h7E, 7'h7E), 1'b1, 1'b0);

        // random segments
        for (int s = 0; s < 250; s++) begin
            r = $urandom_range(0, 9);
            if (r < 7)
                x = pat(1'($urandom_range(0, 1)), digit_pat[$urandom_range(0, 9)],
                        digit_pat[$urandom_range(0, 9)]);
            else if (r == 7)
                x = pat(1'($urandom_range(0, 1)), digit_pat[$urandom_range(0, 9)],
                        7'($urandom_range(1, 127)));
            else if (r == 8)
                x = pat(1'($urandom_range(0, 1)), 7'h00, 7'h00);
            else
                x = 15'($urandom_range(0, 32767));
            len = $urandom_range(1, 8);
            for (int i = 0; i < len; i++)
                cyc(x, ($urandom_range(0, 3) == 0), ($urandom_range(0, 199) == 0));
        end

        hold(pat(1'b0, 7'h5F, 7'h33), 12, 1'b1);
        @(posedge clk);
        #2;
        n_tests++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL drain got %0d events still pending want 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
